// File: rtl/univ_shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg_pkg
// Shared definitions for the universal shift register and its counter.
//   - MODE_* : operation select encodings for the 2-bit mode input
//   - mode_t : 2-bit mode type
//   - calc_cw: width of a counter that must hold 0..w inclusive
// -----------------------------------------------------------------------------
package univ_shift_reg_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_SHR  = 2'b01;
  localparam mode_t MODE_SHL  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

  // The count must reach w itself (not just w-1), hence w+1 states.
  function automatic int calc_cw(input int w);
    return $clog2(w + 1);
  endfunction

endpackage : univ_shift_reg_pkg

// File: rtl/univ_shift_reg_shift_cnt.sv
// -----------------------------------------------------------------------------
// shift_cnt
// Saturating up-counter: counts inc pulses from 0 up to MAX and then stays
// there; clr returns it to 0 (clr wins over inc). Never wraps.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset (count -> 0)
//   clr    in   synchronous clear
//   inc    in   increment request
//   cnt    out  CW-bit current count
//   at_max out  high while cnt == MAX (decoded from the register)
// -----------------------------------------------------------------------------
module shift_cnt #(
  parameter int MAX = 8,
  parameter int CW  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          at_max
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign at_max = (cnt_q == MAX_C);

endmodule : shift_cnt

// File: rtl/univ_shift_reg.sv
// -----------------------------------------------------------------------------
// univ_shift_reg
// WIDTH-bit universal shift register (hold / shift right / shift left /
// parallel load) with a saturating count of shifts since the last load.
// Optional feature macro: UNIV_SHIFT_REG_ROTATE_EN adds input rot, which
// turns shifts into rotates.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset (q -> RST_VAL, cnt -> 0)
//   mode   in   00 hold, 01 shift right, 10 shift left, 11 load
//   d      in   parallel load data
//   sin_r  in   serial in at the MSB on shift right
//   sin_l  in   serial in at the LSB on shift left
//   rot    in   (macro only) 1 = recirculate the outgoing bit
//   q      out  register contents
//   sout_r out  q[0]
//   sout_l out  q[WIDTH-1]
//   cnt    out  shifts since last load, saturating at WIDTH
//   done   out  cnt == WIDTH
// -----------------------------------------------------------------------------
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  localparam int              CW      = calc_cw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  logic [WIDTH-1:0] reg_q;
  logic [WIDTH-1:0] reg_d;
  logic             fill_r;
  logic             fill_l;
  logic             cnt_inc;
  logic             cnt_clr;
  mode_t            mode_sel;

  assign mode_sel = mode;

  // Bit entering the vacated end: external serial input, or the bit that is
  // leaving the opposite end when rotating.
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  assign fill_r = rot ? reg_q[0]       : sin_r;
  assign fill_l = rot ? reg_q[WIDTH-1] : sin_l;
`else
  assign fill_r = sin_r;
  assign fill_l = sin_l;
`endif

  always_comb begin
    reg_d   = reg_q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    case (mode_sel)
      MODE_SHR: begin
        reg_d   = {fill_r, reg_q[WIDTH-1:1]};
        cnt_inc = 1'b1;
      end
      MODE_SHL: begin
        reg_d   = {reg_q[WIDTH-2:0], fill_l};
        cnt_inc = 1'b1;
      end
      MODE_LOAD: begin
        reg_d   = d;
        cnt_clr = 1'b1;
      end
      default: begin
        reg_d = reg_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_q <= RST_VAL;
    end else begin
      reg_q <= reg_d;
    end
  end

  shift_cnt #(
    .MAX (WIDTH),
    .CW  (CW)
  ) u_shift_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .cnt    (cnt),
    .at_max (done)
  );

  assign q      = reg_q;
  assign sout_r = reg_q[0];
  assign sout_l = reg_q[WIDTH-1];

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg
// Directed bench for univ_shift_reg (WIDTH = 8, RST_VAL = 8'hA5). Inputs are
// driven 1 time unit after a rising edge; outputs are sampled there as well.
// Rotate scenario is compiled only when UNIV_SHIFT_REG_ROTATE_EN is defined.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk;
  logic             rst;
  logic [1:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_r;
  logic             sin_l;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  logic             rot;
`endif
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic [CW-1:0]    cnt;
  logic             done;

  int errors = 0;
  int checks = 0;

  univ_shift_reg #(
    .WIDTH   (WIDTH),
    .RST_VAL (8'hA5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .d      (d),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    .rot    (rot),
`endif
    .q      (q),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .cnt    (cnt),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock transaction: apply current inputs at the next rising edge,
  // then move 1 unit past it so outputs are settled and inputs can change.
  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t mode=%b d=%h sin_r=%b sin_l=%b -> q=%h cnt=%0d done=%b",
             $time, mode, d, sin_r, sin_l, q, cnt, done);
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 2'b11; d = 8'h00; sin_r = 1'b0; sin_l = 1'b0;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    rot = 1'b0;
`endif
    #1;
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL reset_q: got %h want a5", q); end
    checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if ({sout_l, sout_r} !== 2'b11) begin errors++; $display("FAIL reset_sout: got %b want 11", {sout_l, sout_r}); end
    // Reset held across an edge with mode=load must still win.
    step();
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL reset_held_q: got %h want a5", q); end
    rst = 1'b0;
  endtask

  task automatic test_shift_right();
    logic [7:0] exp_sout;
    exp_sout = 8'b1001_0110; // expected sout_r sequence read LSB first: 0,1,1,0,1,0,0,1
    mode = 2'b11; d = 8'b1001_0110;
    step();
    checks++; if (q !== 8'h96 || cnt !== 4'd0) begin errors++; $display("FAIL shr_load: got q=%h cnt=%0d want q=96 cnt=0", q, cnt); end
    mode = 2'b01; sin_r = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (sout_r !== exp_sout[i]) begin errors++; $display("FAIL shr_sout_%0d: got %b want %b", i, sout_r, exp_sout[i]); end
      step();
      checks++; if (cnt !== 4'(i + 1)) begin errors++; $display("FAIL shr_cnt_%0d: got %0d want %0d", i, cnt, i + 1); end
      checks++; if (done !== (i == 7)) begin errors++; $display("FAIL shr_done_%0d: got %b want %b", i, done, (i == 7)); end
    end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL shr_final_q: got %h want 00", q); end
  endtask

  task automatic test_saturation();
    logic [7:0] exp_q [3];
    exp_q = '{8'h01, 8'h03, 8'h07};
    mode = 2'b10; sin_l = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL sat_q_%0d: got %h want %h", i, q, exp_q[i]); end
      checks++; if (cnt !== 4'd8 || done !== 1'b1) begin errors++; $display("FAIL sat_cnt_%0d: got cnt=%0d done=%b want 8/1", i, cnt, done); end
    end
    mode = 2'b11; d = 8'h5A;
    step();
    checks++; if (q !== 8'h5A || cnt !== 4'd0 || done !== 1'b0) begin
      errors++; $display("FAIL sat_reload: got q=%h cnt=%0d done=%b want 5a/0/0", q, cnt, done);
    end
  endtask

  task automatic test_hold_mix();
    logic [1:0] m_seq [5];
    logic [7:0] q_seq [5];
    logic [3:0] c_seq [5];
    m_seq = '{2'b11, 2'b10, 2'b00, 2'b00, 2'b01};
    q_seq = '{8'h3C, 8'h78, 8'h78, 8'h78, 8'hBC};
    c_seq = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
    d = 8'h3C; sin_l = 1'b0; sin_r = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mode = m_seq[i];
      step();
      checks++; if (q !== q_seq[i] || cnt !== c_seq[i]) begin
        errors++; $display("FAIL mix_%0d: got q=%h cnt=%0d want q=%h cnt=%0d", i, q, cnt, q_seq[i], c_seq[i]);
      end
    end
    checks++; if (sout_l !== 1'b1 || sout_r !== 1'b0) begin errors++; $display("FAIL mix_sout: got %b%b want 10", sout_l, sout_r); end
  endtask

  task automatic test_async_reset();
    mode = 2'b11; d = 8'hFF;
    step();
    mode = 2'b01; sin_r = 1'b1;
    repeat (3) step();
    checks++; if (q !== 8'hFF || cnt !== 4'd3) begin errors++; $display("FAIL arst_pre: got q=%h cnt=%0d want ff/3", q, cnt); end
    #2 rst = 1'b1;
    #1;
    checks++; if (q !== 8'hA5 || cnt !== 4'd0 || done !== 1'b0) begin
      errors++; $display("FAIL arst_immediate: got q=%h cnt=%0d done=%b want a5/0/0", q, cnt, done);
    end
    step();
    checks++; if (q !== 8'hA5 || cnt !== 4'd0) begin errors++; $display("FAIL arst_held: got q=%h cnt=%0d want a5/0", q, cnt); end
    rst = 1'b0; sin_r = 1'b0;
    step();
    checks++; if (q !== 8'h52 || cnt !== 4'd1) begin errors++; $display("FAIL arst_release: got q=%h cnt=%0d want 52/1", q, cnt); end
  endtask

`ifdef UNIV_SHIFT_REG_ROTATE_EN
  task automatic test_rotate();
    mode = 2'b11; d = 8'h81; rot = 1'b1;
    step();
    sin_l = 1'b0; sin_r = 1'b0;
    mode = 2'b10;
    step();
    checks++; if (q !== 8'h03) begin errors++; $display("FAIL rot_shl: got %h want 03", q); end
    mode = 2'b01;
    step();
    checks++; if (q !== 8'h81) begin errors++; $display("FAIL rot_shr1: got %h want 81", q); end
    step();
    checks++; if (q !== 8'hC0 || cnt !== 4'd3) begin errors++; $display("FAIL rot_shr2: got q=%h cnt=%0d want c0/3", q, cnt); end
    rot = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_shift_right();
    test_saturation();
    test_hold_mix();
    test_async_reset();
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    test_rotate();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_univ_shift_reg
